// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
package rf_wb_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 64;
   localparam int REG_ZERO  = 0;

   typedef struct packed {
      logic                 wen;
      logic [RF_ADDR_W-1:0] waddr;
      logic [RF_DATA_W-1:0] wdata;
   } wb_port_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Rotating-priority picker: the first set valid bit at or after ptr (mod N) wins.
module rr_pick #(
   parameter int N    = 2,
   parameter int ID_W = 1
) (
   input  logic [N-1:0]    valid,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] idx
);

   logic            found;
   logic [ID_W-1:0] cand;
   int              j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j    = (int'(ptr) + k) % N;
         cand = ID_W'(j);
         if (!found && valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between NREQ producers; output is registered.
// Build option: RF_WB_ARB_RR_EN selects round-robin, otherwise fixed lowest-index priority.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int  NREQ   = 2,
   parameter int  ADDR_W = RF_ADDR_W,
   parameter int  DATA_W = RF_DATA_W,
   localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic                   rf_wen,
   output logic [ADDR_W-1:0]      rf_waddr,
   output logic [DATA_W-1:0]      rf_wdata,
   output logic [ID_W-1:0]        grant_id
);

   typedef struct packed {
      logic              wen;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } wb_t;

   logic [NREQ-1:0]   grant;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   ptr;
   logic              xfer;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   wb_t               wb_d, wb_q;
   logic [ID_W-1:0]   gid_d, gid_q;

   rr_pick #(
      .N    (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx)
   );

   // Ready is masked while reset is held so nothing can be accepted.
   assign req_ready = rst ? grant : '0;
   assign xfer      = |req_ready;
   assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_data  = req_data[int'(win_idx)*DATA_W +: DATA_W];

`ifdef RF_WB_ARB_RR_EN
   logic [ID_W-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   // x0 transfers still load address/data/id but never raise the strobe.
   always_comb begin
      wb_d     = wb_q;
      gid_d    = gid_q;
      wb_d.wen = 1'b0;
      if (xfer) begin
         wb_d.wen   = (win_addr != ADDR_W'(REG_ZERO));
         wb_d.waddr = win_addr;
         wb_d.wdata = win_data;
         gid_d      = win_idx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_q  <= '0;
         gid_q <= '0;
      end else begin
         wb_q  <= wb_d;
         gid_q <= gid_d;
      end
   end

   assign rf_wen   = wb_q.wen;
   assign rf_waddr = wb_q.waddr;
   assign rf_wdata = wb_q.wdata;
   assign grant_id = gid_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, reset corner cases, randomized traffic vs. model.
module tb_rf_wb_arbiter;
   import rf_wb_pkg::*;

   localparam int NREQ   = 2;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 64;
`ifdef RF_WB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   rf_wen;
   logic [ADDR_W-1:0]      rf_waddr;
   logic [DATA_W-1:0]      rf_wdata;
   logic [0:0]             grant_id;

   int checks = 0;
   int errors = 0;

   int                m_ptr;
   logic              m_wen;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   int                m_gid;

   logic [ADDR_W-1:0] ra [NREQ];
   logic [DATA_W-1:0] rd [NREQ];

   typedef struct {
      logic [1:0]  v;
      logic [4:0]  a0, a1;
      logic [63:0] d0, d1;
      logic [1:0]  rdy;
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic        gid;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .grant_id  (grant_id)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner = lowest set bit of the valid vector rotated right by p.
   function automatic int pick_idx(input logic [1:0] v, input int p);
      int dbl, low, pos;
      if (v == 2'b00) return -1;
      dbl = (int'(v) | (int'(v) << NREQ)) >> p;
      low = dbl & -dbl;
      pos = $clog2(low);
      return (p + pos) % NREQ;
   endfunction

   function automatic logic [1:0] exp_ready(input logic [1:0] v);
      int w;
      w = pick_idx(v, m_ptr);
      return (w < 0) ? 2'b00 : 2'(1 << w);
   endfunction

   task automatic drive(input logic [1:0] v);
      req_valid = v;
      req_addr  = {ra[1], ra[0]};
      req_data  = {rd[1], rd[0]};
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_gid   = 0;
   endtask

   task automatic model_edge(output int w);
      w = rst ? pick_idx(req_valid, m_ptr) : -1;
      m_wen = 1'b0;
      if (w >= 0) begin
         m_wen   = (ra[w] != 0);
         m_waddr = ra[w];
         m_wdata = rd[w];
         m_gid   = w;
         m_ptr   = RR ? (w + 1) % NREQ : 0;
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_wen"},   rf_wen,   m_wen);
      chk({tag, "_waddr"}, rf_waddr, m_waddr);
      chk({tag, "_wdata"}, rf_wdata, m_wdata);
      chk({tag, "_gid"},   grant_id, m_gid[0]);
   endtask

   initial begin
      int         w;
      logic [1:0] pend;
      int         wait_cnt [NREQ];

      tbl[0] = '{v:2'b10, a0:5'd0, a1:5'd5, d0:64'h0, d1:64'hDEAD,
                 rdy:2'b10, wen:1'b1, waddr:5'd5, wdata:64'hDEAD, gid:1'b1};
      tbl[1] = '{v:2'b00, a0:5'd0, a1:5'd5, d0:64'h0, d1:64'hDEAD,
                 rdy:2'b00, wen:1'b0, waddr:5'd5, wdata:64'hDEAD, gid:1'b1};
      tbl[2] = '{v:2'b11, a0:5'd3, a1:5'd4, d0:64'h33, d1:64'h44,
                 rdy:2'b01, wen:1'b1, waddr:5'd3, wdata:64'h33, gid:1'b0};
      tbl[3] = '{v:2'b11, a0:5'd3, a1:5'd4, d0:64'h33, d1:64'h44,
                 rdy:(RR ? 2'b10 : 2'b01), wen:1'b1, waddr:(RR ? 5'd4 : 5'd3),
                 wdata:(RR ? 64'h44 : 64'h33), gid:RR};
      tbl[4] = '{v:2'b11, a0:5'd3, a1:5'd4, d0:64'h33, d1:64'h44,
                 rdy:2'b01, wen:1'b1, waddr:5'd3, wdata:64'h33, gid:1'b0};
      tbl[5] = tbl[3];
      tbl[6] = '{v:2'b01, a0:5'd0, a1:5'd4, d0:64'h1234, d1:64'h44,
                 rdy:2'b01, wen:1'b0, waddr:5'd0, wdata:64'h1234, gid:1'b0};
      tbl[7] = '{v:2'b11, a0:5'd9, a1:5'd10, d0:64'h99, d1:64'hAA,
                 rdy:(RR ? 2'b10 : 2'b01), wen:1'b1, waddr:(RR ? 5'd10 : 5'd9),
                 wdata:(RR ? 64'hAA : 64'h99), gid:RR};

      // Reset held with every requester valid
      rst   = 1'b0;
      ra[0] = 5'd1; rd[0] = 64'h11;
      ra[1] = 5'd2; rd[1] = 64'h22;
      drive(2'b11);
      model_reset();
      @(negedge clk);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_wen",   rf_wen,    1'b0);
      chk("rst_waddr", rf_waddr,  5'd0);
      chk("rst_wdata", rf_wdata,  64'h0);
      chk("rst_gid",   grant_id,  1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("release_ready", req_ready, 2'b01);

      for (int i = 0; i < 8; i++) begin
         ra[0] = tbl[i].a0; rd[0] = tbl[i].d0;
         ra[1] = tbl[i].a1; rd[1] = tbl[i].d1;
         drive(tbl[i].v);
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
         @(posedge clk);
         model_edge(w);
         #1;
         chk($sformatf("tbl%0d_wen", i),   rf_wen,   tbl[i].wen);
         chk($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].waddr);
         chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].wdata);
         chk($sformatf("tbl%0d_gid", i),   grant_id, tbl[i].gid);
      end

      // Reset asserted between edges while a write to r7 is in flight
      ra[0] = 5'd7; rd[0] = 64'h77;
      drive(2'b01);
      @(negedge clk);
      chk("mid_ready", req_ready, 2'b01);
      @(posedge clk);
      model_edge(w);
      #1;
      chk("mid_wen_before", rf_wen,   1'b1);
      chk("mid_waddr_before", rf_waddr, 5'd7);
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("mid_wen_async",   rf_wen,    1'b0);
      chk("mid_waddr_async", rf_waddr,  5'd0);
      chk("mid_wdata_async", rf_wdata,  64'h0);
      chk("mid_ready_rst",   req_ready, 2'b00);
      @(posedge clk);
      #2 chk("mid_no_write7", rf_wen, 1'b0);
      rst   = 1'b1;
      ra[1] = 5'd8; rd[1] = 64'h88;
      drive(2'b11);
      #1 chk("post_rst_ready", req_ready, 2'b01);
      drive(2'b00);
      @(posedge clk);
      model_edge(w);
      #1;

      // Randomized traffic obeying the hold-until-accepted rule
      pend = 2'b00;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6) begin
               pend[i]     = 1'b1;
               ra[i]       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               rd[i]       = {$urandom, $urandom};
               wait_cnt[i] = 0;
            end
         end
         drive(pend);
         @(negedge clk);
         chk("rnd_ready", req_ready, exp_ready(req_valid));
         check_outs("rnd");
         @(posedge clk);
         model_edge(w);
`ifdef RF_WB_ARB_RR_EN
         if (w >= 0) begin
            checks++;
            if (wait_cnt[w] >= NREQ) begin
               errors++;
               $display("FAIL rnd_fairness: req%0d waited %0d cycles, limit %0d", w, wait_cnt[w], NREQ - 1);
            end
         end
`endif
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
               if (i == w) pend[i] = 1'b0;
               else        wait_cnt[i]++;
            end
         end
         #1;
      end
      drive(2'b00);
      @(negedge clk);
      check_outs("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that shares the register file's single write port between NREQ producers (ALU result, LSU load return, CSR read result, ...). Each producer offers a write through a valid/ready handshake. The arbiter grants at most one per cycle and drives a registered write strobe, address and data into the register-file array one cycle after acceptance. Writes to x0 are consumed but suppressed.

## Interface
- NREQ, 2: number of requesters, 2..8
- ADDR_W, 5: register index width
- DATA_W, 64: register data width
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock domain; reset is asynchronous and active-low
- req_valid  in  NREQ  bit i: requester i offers a write
- req_ready  out  NREQ  bit i: requester i's write is accepted this cycle (one-hot or zero)
- req_addr  in  NREQ*ADDR_W  packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed write data, same packing
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write index (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- grant_id  out  clog2(NREQ)  index of the requester behind the current rf_wen (registered)

## Operation
- Transfer on requester i: req_valid[i] && req_ready[i] at a rising edge.
- Requester rules: once valid is high, it stays high with addr and data stable until transfer. Violations are a requester bug.
- Grant: combinational from req_valid and the priority pointer `ptr`. The first valid index scanning ptr, ptr+1, ... mod NREQ wins. req_ready is the one-hot of the winner and all-zero if no valid.
- req_ready may depend on req_valid. No other combinational path to inputs.
- Pointer update on a transfer by i: ptr <= (i+1) mod NREQ. No transfer: ptr holds.
- Output stage, every cycle:
  - rf_wen <= transfer && (winner addr != 0).
  - rf_waddr, rf_wdata and grant_id load the winner's values on any transfer, including an x0 transfer.
  - With no transfer, these three hold their values.
- x0 request: accepted (ready=1), rotates ptr, and produces no write.
- The write port never back-pressures. The arbiter accepts one request every cycle that any valid is high.

## Timing
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0, ptr=0.
  - req_ready=0 while rst is low, forced combinationally.
- Reset assertion is asynchronous and clears all state immediately. An in-flight write is dropped: rf_wen falls without waiting for clk.
- Deassertion is synchronized upstream. The first grant is possible in the first cycle after release.
- Latency: transfer at edge N, then rf_wen/addr/data valid during cycle N to N+1 and written by the array at edge N+1.
- Throughput: 1 write per cycle.
- Fairness: a continuously-valid requester is granted within NREQ cycles.
- Same-address writes from two requesters in consecutive grants land in grant order. Ordering across requesters is the issue logic's responsibility.

## Configuration
- RF_WB_ARB_RR_EN defined: round-robin as described, with the ptr register present.
- RF_WB_ARB_RR_EN undefined:
  - fixed priority, lowest index wins;
  - ptr is removed and treated as constant 0;
  - fairness is not guaranteed;
  - all other behaviour is identical.

## Structure
- Shared package rf_wb_pkg:
  - default ADDR_W/DATA_W constants;
  - REG_ZERO index constant (0);
  - typedef for the write-port bundle (wen, waddr, wdata).
- One sub-module, rr_pick: given a valid vector and a pointer, return a one-hot grant and its encoded index. It is reused for fixed priority with pointer=0.

## Test plan
- Reset: hold rst=0 with all valids high -> req_ready=0, rf_wen=0, rf_waddr=0, rf_wdata=0. Release -> first cycle ready=01 (NREQ=2, ptr=0).
- Single requester: req1 valid, addr=5, data=0xDEAD -> ready=10 same cycle. Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD, grant_id=1. The cycle after, rf_wen=0.
- Contention (RR_EN): both valid continuously for 4 cycles -> grants 0,1,0,1. rf_wen is high every cycle after the first.
- Contention (RR_EN undefined): same stimulus -> req0 granted all 4 cycles and req1 starved.
- x0 write: req0 valid, addr=0, data=0x1234 -> ready=01 and ptr advances to 1. Next cycle rf_wen=0, rf_waddr=0, rf_wdata=0x1234.
- Reset mid-write: transfer addr=7, then assert rst between edges -> rf_wen drops to 0 before the next edge and register 7 is not written.
